// File: rtl/jk_pkg.sv
// Shared constants and the JK excitation rule for the jk_excite_gen drive/check engine.
package jk_pkg;

    localparam int XF_ZERO   = 0;
    localparam int XF_ONE    = 1;
    localparam int ERR_CNT_W = 8;

    // Returns {J,K} that moves a JK flop from present p to target t; x becomes xfill.
    function automatic logic [1:0] jk_excite(input logic p, input logic t, input logic xfill);
        logic [1:0] jk;
        case ({p, t})
            2'b00:   jk = {1'b0, xfill};
            2'b01:   jk = {1'b1, xfill};
            2'b10:   jk = {xfill, 1'b1};
            2'b11:   jk = {xfill, 1'b0};
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_excite_gen_if.sv
// Target-word stream plus JK drive/feedback bundle between a word source and jk_excite_gen.
interface jk_excite_gen_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         en;
    logic [N-1:0] j;
    logic [N-1:0] k;
    logic         drv_valid;
    logic [N-1:0] q_fb;

    modport master (
        output in_valid, in_data, en, q_fb,
        input  in_ready, j, k, drv_valid
    );

    modport slave (
        input  in_valid, in_data, en, q_fb,
        output in_ready, j, k, drv_valid
    );
endinterface

// File: rtl/jk_fifo.sv
// N-bit x DEPTH synchronous FIFO with registered occupancy; no write-to-read bypass.
module jk_fifo
    import jk_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [N-1:0]             push_data,
    input  logic                     pop,
    output logic [N-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [N-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Guard against overflow/underflow even if the caller gets it wrong.
    assign push_ok_s = push && (level_r != LW'(DEPTH));
    assign pop_ok_s  = pop && (level_r != LW'(0));
    assign pop_data  = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Storage, pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {N{1'b0}};
            end
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/jk_excite_gen.sv
// Buffers target words, drives JK excitation from a present-state model, and checks fed-back Q.
module jk_excite_gen
    import jk_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int XFILL = XF_ZERO
) (
    input  logic                   clk,
    input  logic                   rst_n,
    jk_excite_gen_if.slave         bus,
    output logic                   err,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    input  logic                   err_clr,
    output logic [$clog2(DEPTH):0] level
);
    localparam int   LW     = $clog2(DEPTH) + 1;
    localparam logic XF_BIT = (XFILL == XF_ONE) ? 1'b1 : 1'b0;

    logic [LW-1:0]        level_s;
    logic                 in_ready_s;
    logic                 push_s;
    logic                 pop_s;
    logic [N-1:0]         head_s;
    logic [N-1:0]         j_nxt_s;
    logic [N-1:0]         k_nxt_s;
    logic                 mismatch_s;

    logic [N-1:0]         j_r;
    logic [N-1:0]         k_r;
    logic                 drv_valid_r;
    logic [N-1:0]         q_model_r;
    logic [N-1:0]         exp_q_r;
    logic                 arm_r;
    logic                 err_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;

    assign in_ready_s = (level_s != LW'(DEPTH));
    assign push_s     = bus.in_valid && in_ready_s;
    assign pop_s      = bus.en && (level_s != LW'(0));

    jk_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (bus.in_data),
        .pop       (pop_s),
        .pop_data  (head_s),
        .level     (level_s)
    );

    // Per-bit excitation of the FIFO head against the modelled present state.
    always_comb begin
        j_nxt_s = {N{1'b0}};
        k_nxt_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            {j_nxt_s[i], k_nxt_s[i]} = jk_excite(q_model_r[i], head_s[i], XF_BIT);
        end
    end

    // Drive registers: excitation on a pop, hold (J=K=0) otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j_r         <= {N{1'b0}};
            k_r         <= {N{1'b0}};
            drv_valid_r <= 1'b0;
            q_model_r   <= {N{1'b0}};
        end else if (pop_s) begin
            j_r         <= j_nxt_s;
            k_r         <= k_nxt_s;
            drv_valid_r <= 1'b1;
            q_model_r   <= head_s;
        end else begin
            j_r         <= {N{1'b0}};
            k_r         <= {N{1'b0}};
            drv_valid_r <= 1'b0;
            q_model_r   <= q_model_r;
        end
    end

    // The flops lag the model by one edge, so compare against a delayed copy once armed.
    assign mismatch_s = arm_r && (bus.q_fb != exp_q_r);

    // Checker state: delayed model, arming flag, sticky error and saturating count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q_r   <= {N{1'b0}};
            arm_r     <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else begin
            exp_q_r <= q_model_r;
            arm_r   <= 1'b1;
            if (err_clr) begin
                err_r     <= 1'b0;
                err_cnt_r <= {ERR_CNT_W{1'b0}};
            end else if (mismatch_s) begin
                err_r <= 1'b1;
                if (err_cnt_r != {ERR_CNT_W{1'b1}}) begin
                    err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
                end else begin
                    err_cnt_r <= err_cnt_r;
                end
            end else begin
                err_r     <= err_r;
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.j         = j_r;
    assign bus.k         = k_r;
    assign bus.drv_valid = drv_valid_r;
    assign err           = err_r;
    assign err_cnt       = err_cnt_r;
    assign level         = level_s;

endmodule

// File: tb/tb_jk_excite_gen.sv
// Drives two jk_excite_gen instances (XFILL 0 and 1) from one stimulus and checks them against a queue model.
module tb_jk_excite_gen;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         err_clr;
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         en;
    logic         force_b;

    logic [N-1:0] fq0, fq1;
    logic         err0, err1;
    logic [7:0]   cnt0, cnt1;
    logic [LW-1:0] level0, level1;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] mq[$];
    logic [N-1:0] mdl_q;
    logic [N-1:0] ej0, ek0, ej1, ek1;
    logic         edrv;
    logic         eerr;
    int           ecnt;
    int           edges;

    always #5 clk = ~clk;

    jk_excite_gen_if #(.N(N)) bus0 ();
    jk_excite_gen_if #(.N(N)) bus1 ();

    assign bus0.in_valid = in_valid;
    assign bus0.in_data  = in_data;
    assign bus0.en       = en;
    assign bus0.q_fb     = fq0 ^ {{(N-1){1'b0}}, force_b};
    assign bus1.in_valid = in_valid;
    assign bus1.in_data  = in_data;
    assign bus1.en       = en;
    assign bus1.q_fb     = fq1 ^ {{(N-1){1'b0}}, force_b};

    jk_excite_gen #(.N(N), .DEPTH(DEPTH), .XFILL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .err(err0), .err_cnt(cnt0),
        .err_clr(err_clr), .level(level0)
    );

    jk_excite_gen #(.N(N), .DEPTH(DEPTH), .XFILL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .err(err1), .err_cnt(cnt1),
        .err_clr(err_clr), .level(level1)
    );

    // The driven JK flop banks, sharing rst_n with the generators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq0 <= '0;
            fq1 <= '0;
        end else begin
            fq0 <= (bus0.j & ~fq0) | (~bus0.k & fq0);
            fq1 <= (bus1.j & ~fq1) | (~bus1.k & fq1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("level0", 32'(level0), 32'(mq.size()));
        chk("ready0", 32'(bus0.in_ready), 32'(mq.size() != DEPTH));
        chk("j0", 32'(bus0.j), 32'(ej0));
        chk("k0", 32'(bus0.k), 32'(ek0));
        chk("drv0", 32'(bus0.drv_valid), 32'(edrv));
        chk("err0", 32'(err0), 32'(eerr));
        chk("cnt0", 32'(cnt0), 32'(ecnt));
        chk("level1", 32'(level1), 32'(mq.size()));
        chk("ready1", 32'(bus1.in_ready), 32'(mq.size() != DEPTH));
        chk("j1", 32'(bus1.j), 32'(ej1));
        chk("k1", 32'(bus1.k), 32'(ek1));
        chk("drv1", 32'(bus1.drv_valid), 32'(edrv));
        chk("err1", 32'(err1), 32'(eerr));
        chk("cnt1", 32'(cnt1), 32'(ecnt));
    endtask

    task automatic model_reset();
        mq.delete();
        mdl_q = '0;
        ej0 = '0; ek0 = '0; ej1 = '0; ek1 = '0;
        edrv = 1'b0;
        eerr = 1'b0;
        ecnt = 0;
        edges = 0;
    endtask

    // Predict one clock edge from the current inputs, take the edge, then compare.
    task automatic tick();
        bit           do_push, do_pop;
        logic [N-1:0] t;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = en && (mq.size() != 0);
        ej0 = '0; ek0 = '0; ej1 = '0; ek1 = '0;
        edrv = 1'b0;
        if (do_pop) begin
            t    = mq.pop_front();
            // Set where going 0->1, reset where going 1->0; x bits take the fill value.
            ej0  = ~mdl_q & t;
            ek0  = mdl_q & ~t;
            ej1  = (~mdl_q & t) | mdl_q;
            ek1  = (mdl_q & ~t) | ~mdl_q;
            mdl_q = t;
            edrv = 1'b1;
        end
        if (do_push) mq.push_back(in_data);
        if (err_clr) begin
            eerr = 1'b0;
            ecnt = 0;
        end else if (edges >= 1 && force_b) begin
            eerr = 1'b1;
            if (ecnt < 255) ecnt++;
        end
        edges++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; err_clr = 1'b0; in_valid = 1'b0; in_data = '0; en = 1'b0; force_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;

        // Two directed words, then let them settle through the flops.
        en = 1'b1; in_valid = 1'b1; in_data = 4'b1010;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        in_valid = 1'b1; in_data = 4'b0110;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();

        // Fill past capacity with the drain stopped, then drain.
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = N'($urandom);
            tick();
        end
        in_valid = 1'b0; en = 1'b1;
        repeat (6) tick();

        // Injected feedback errors, clear, clear-versus-mismatch priority.
        force_b = 1'b1;
        repeat (3) tick();
        force_b = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        force_b = 1'b1;
        tick();
        err_clr = 1'b0;
        repeat (300) tick();
        force_b = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Simultaneous push and pop at level 2.
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = N'($urandom);
            tick();
        end
        en = 1'b1; in_data = N'($urandom);
        repeat (2) tick();
        in_valid = 1'b0;
        repeat (4) tick();

        // Asynchronous reset mid-drain at level 3.
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = N'($urandom);
            tick();
        end
        in_valid = 1'b0; en = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;
        repeat (4) tick();

        // Randomised traffic with occasional injected errors and clears.
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = N'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            force_b  = ($urandom_range(0, 15) == 0);
            err_clr  = ($urandom_range(0, 31) == 0);
            tick();
        end
        force_b = 1'b0; err_clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
